// File: rtl/lpc_autocorr_frame.sv
// Frame-based autocorrelation engine: accumulates R[0..ORDER] over FRAME_LEN
// samples, then streams the scaled, saturated lags one per handshake.
module lpc_autocorr_frame #(
  parameter int DATA_W    = 16,
  parameter int ORDER     = 10,
  parameter int FRAME_LEN = 160,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 20,
  parameter int OUT_W     = 16,
  localparam int LAG_W    = (ORDER > 0) ? $clog2(ORDER + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic signed [OUT_W-1:0]  r_data,
  output logic [LAG_W-1:0]         r_lag,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic                     r_last,
  output logic                     r_sat,
  output logic                     busy
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int PW    = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(-(longint'(1) <<< (OUT_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_OUTPUT} state_t;

  state_t                    r_state, w_nstate;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_fcnt;
  logic signed [DATA_W-1:0]  r_dly  [1:ORDER];
  logic signed [PW-1:0]      r_prod [0:ORDER];
  logic                      r_pvld;
  logic signed [ACC_W-1:0]   r_acc  [0:ORDER];

  logic                      r_xready, r_busy, r_rvalid, r_rlast, r_rsat;
  logic signed [OUT_W-1:0]   r_rdata;
  logic [LAG_W-1:0]          r_rlag;

  logic                      w_acc, w_last_samp, w_done;
  logic signed [PW-1:0]      w_xe;
  logic signed [PW-1:0]      w_tap [0:ORDER];
  logic [LAG_W-1:0]          w_nlag;
  logic signed [ACC_W-1:0]   w_sel, w_shift;
  logic signed [OUT_W-1:0]   w_fdata;
  logic                      w_fsat;

  assign w_acc       = x_valid & r_xready;
  assign w_last_samp = w_acc && (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_done      = r_rvalid & r_ready & (r_rlag == LAG_W'(ORDER));

  // Sign-extended taps; tap 0 is the incoming sample itself.
  always_comb begin
    w_xe     = {{DATA_W{x_in[DATA_W-1]}}, x_in};
    w_tap[0] = w_xe;
    for (int k = 1; k <= ORDER; k++)
      w_tap[k] = {{DATA_W{r_dly[k][DATA_W-1]}}, r_dly[k]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nstate;
  end

  // Next-state logic.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:   if (w_acc) w_nstate = w_last_samp ? S_FLUSH : S_ACCUM;
      S_ACCUM:  if (w_last_samp) w_nstate = S_FLUSH;
      S_FLUSH:  if (r_fcnt) w_nstate = S_OUTPUT;
      S_OUTPUT: if (w_done) w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
  end

  // Sample counter and two-cycle flush timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_fcnt <= 1'b0;
    end else begin
      r_fcnt <= (r_state == S_FLUSH) && !r_fcnt;
      if (w_done)      r_cnt <= '0;
      else if (w_acc)  r_cnt <= w_last_samp ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Delay line shifts only on accepted samples; cleared after each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= ORDER; k++) r_dly[k] <= '0;
    end else if (w_done) begin
      for (int k = 1; k <= ORDER; k++) r_dly[k] <= '0;
    end else if (w_acc) begin
      r_dly[1] <= x_in;
      for (int k = 2; k <= ORDER; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // Product stage: x[n]*x[n-k] for every lag on each accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pvld <= 1'b0;
      for (int k = 0; k <= ORDER; k++) r_prod[k] <= '0;
    end else begin
      r_pvld <= w_acc;
      if (w_acc)
        for (int k = 0; k <= ORDER; k++) r_prod[k] <= w_xe * w_tap[k];
    end
  end

  // Accumulate stage: only the cycle after an acceptance adds a product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= ORDER; k++) r_acc[k] <= '0;
    end else if (w_done) begin
      for (int k = 0; k <= ORDER; k++) r_acc[k] <= '0;
    end else if (r_pvld) begin
      for (int k = 0; k <= ORDER; k++)
        r_acc[k] <= r_acc[k] + {{(ACC_W-PW){r_prod[k][PW-1]}}, r_prod[k]};
    end
  end

  // Lag to present next: 0 when the output stage is empty, else current+1.
  always_comb begin
    w_nlag = r_rvalid ? r_rlag + LAG_W'(1) : '0;
    w_sel  = '0;
    for (int k = 0; k <= ORDER; k++)
      if (w_nlag == LAG_W'(k)) w_sel = r_acc[k];
    w_shift = w_sel >>> OUT_SHIFT;
    if (w_shift > C_MAX) begin
      w_fdata = {1'b0, {(OUT_W-1){1'b1}}};
      w_fsat  = 1'b1;
    end else if (w_shift < C_MIN) begin
      w_fdata = {1'b1, {(OUT_W-1){1'b0}}};
      w_fsat  = 1'b1;
    end else begin
      w_fdata = w_shift[OUT_W-1:0];
      w_fsat  = 1'b0;
    end
  end

  // Registered output stage; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rlag   <= '0;
      r_rlast  <= 1'b0;
      r_rsat   <= 1'b0;
    end else if (r_state == S_OUTPUT) begin
      if (!r_rvalid || (r_ready && !w_done)) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_fdata;
        r_rlag   <= w_nlag;
        r_rsat   <= w_fsat;
        r_rlast  <= (w_nlag == LAG_W'(ORDER));
      end else if (w_done) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rlag   <= '0;
        r_rsat   <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  // Registered status flags so they read low throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xready <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_xready <= (w_nstate == S_IDLE) || (w_nstate == S_ACCUM);
      r_busy   <= (w_nstate != S_IDLE);
    end
  end

  assign x_ready = r_xready;
  assign busy    = r_busy;
  assign r_valid = r_rvalid;
  assign r_data  = r_rdata;
  assign r_lag   = r_rlag;
  assign r_last  = r_rlast;
  assign r_sat   = r_rsat;

endmodule

// File: tb/tb_lpc_autocorr_frame.sv
// Bench for lpc_autocorr_frame: reference-model scoreboard plus a frame table
// with spot values, latency, stall-hold and reset sequences.
module tb_lpc_autocorr_frame;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] x_in = '0;
  logic               x_valid = 1'b0;
  logic               x_ready;
  logic signed [15:0] r_data;
  logic [3:0]         r_lag;
  logic               r_valid;
  logic               r_ready = 1'b1;
  logic               r_last;
  logic               r_sat;
  logic               busy;

  lpc_autocorr_frame dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .r_data(r_data), .r_lag(r_lag), .r_valid(r_valid), .r_ready(r_ready),
    .r_last(r_last), .r_sat(r_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int lag; int data; bit sat; bit last; } exp_t;
  typedef struct { int kind; bit gaps; int rmode; int e0; int e1; int e10; bit s0; } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_mode = 0;
  int   got [0:10];
  bit   gotsat [0:10];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int samp(input int kind, input int n);
    case (kind)
      0:       return 1000;
      1:       return (n == 0) ? 32767 : 0;
      default: return (n % 2 == 0) ? 16384 : -16384;
    endcase
  endfunction

  // Reference model: direct sum, floor shift, clip.
  task automatic push_expected(input int kind);
    longint acc, s;
    exp_t e;
    for (int k = 0; k <= 10; k++) begin
      acc = 0;
      for (int n = k; n < 160; n++)
        acc += longint'(samp(kind, n)) * longint'(samp(kind, n - k));
      s = acc >>> 20;
      if (s > 32767)       begin e.data = 32767;  e.sat = 1'b1; end
      else if (s < -32768) begin e.data = -32768; e.sat = 1'b1; end
      else                 begin e.data = int'(s); e.sat = 1'b0; end
      e.lag  = k;
      e.last = (k == 10);
      sb.push_back(e);
    end
  endtask

  // Output monitor: drives r_ready, checks holds, pops scoreboard on handshake.
  bit          hold = 1'b0;
  logic [22:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      hold = 1'b0;
    end else begin
      r_ready = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (hold) check("hold_stable", {r_valid, r_data, r_lag, r_last, r_sat}, held);
      if (r_valid) check("x_ready_low_in_output", x_ready, 0);
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = sb.pop_front();
          check("r_lag", r_lag, e.lag);
          check("r_data", r_data, e.data);
          check("r_sat", r_sat, e.sat);
          check("r_last", r_last, e.last);
          got[r_lag]    = int'(r_data);
          gotsat[r_lag] = r_sat;
        end
      end
      hold = r_valid && !r_ready;
      held = {r_valid, r_data, r_lag, r_last, r_sat};
    end
  end

  // Offer samples until nsamp are accepted; the last one lands on the next posedge.
  task automatic drive_frame(input int kind, input bit gaps, input int nsamp);
    int n = 0;
    int t = 0;
    while (n < nsamp && t < 20000) begin
      @(negedge clk);
      t++;
      x_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      x_in    = 16'(samp(kind, n));
      if (x_valid && x_ready) n++;
    end
    if (n < nsamp) check("drive_timeout", n, nsamp);
  endtask

  task automatic run_frame(input vec_t v);
    int t = 0;
    for (int k = 0; k <= 10; k++) begin got[k] = -999999; gotsat[k] = 1'b0; end
    rr_mode = v.rmode;
    push_expected(v.kind);
    drive_frame(v.kind, v.gaps, 160);
    // Junk offered while the block is flushing/outputting must be ignored.
    @(negedge clk); x_valid = v.gaps; x_in = 16'sd12345;
    @(negedge clk);
    @(negedge clk); check("latency_pre", r_valid, 0);
    @(negedge clk); check("latency_first", r_valid, 1);
    check("latency_lag0", r_lag, 0);
    while (sb.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    check("sb_drained", sb.size(), 0);
    x_valid = 1'b0;
    @(negedge clk);
    check("busy_after", busy, 0);
    check("x_ready_after", x_ready, 1);
    check("spot_R0", got[0], v.e0);
    check("spot_R1", got[1], v.e1);
    check("spot_R10", got[10], v.e10);
    check("spot_sat0", gotsat[0], v.s0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_valid"}, r_valid, 0);
    check({tag, "_r_data"}, r_data, 0);
    check({tag, "_r_lag"}, r_lag, 0);
    check({tag, "_r_last"}, r_last, 0);
    check({tag, "_r_sat"}, r_sat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x_ready"}, x_ready, 0);
  endtask

  vec_t vt [0:5];

  initial begin
    int t;
    vt[0] = '{0, 1'b0, 0, 152, 151, 143, 1'b0};
    vt[1] = '{1, 1'b0, 0, 1023, 0, 0, 1'b0};
    vt[2] = '{2, 1'b0, 0, 32767, -32768, 32767, 1'b1};
    vt[3] = '{0, 1'b1, 1, 152, 151, 143, 1'b0};
    vt[4] = '{1, 1'b0, 1, 1023, 0, 0, 1'b0};
    vt[5] = '{0, 1'b0, 0, 152, 151, 143, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check("idle_x_ready", x_ready, 1);
    check("idle_busy", busy, 0);

    // Table: includes impulse followed directly by constant frame (4 -> 5).
    for (int i = 0; i < 6; i++) run_frame(vt[i]);

    // Reset in the middle of a frame (after 80 samples).
    rr_mode = 0;
    drive_frame(0, 1'b0, 80);
    @(negedge clk);
    x_valid = 1'b0;
    check("mid_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(vt[0]);

    // Reset while presenting lag 4.
    rr_mode = 0;
    push_expected(0);
    drive_frame(0, 1'b0, 160);
    @(negedge clk); x_valid = 1'b0;
    t = 0;
    while (!(r_valid && r_lag == 4) && t < 100) begin @(negedge clk); t++; end
    check("reached_lag4", r_lag, 4);
    check("lag4_data", r_data, 148);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_out");
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

endmodule
